// File: rtl/eks_setup_sequencer.sv
// EksBlowfishSetup sequencer: one salted expandKey(salt, key) call, then 2^cost rounds of
// expandKey(0, key) followed by expandKey(0, salt), with start/done handshake to expandKey.
module eks_setup_sequencer #(
   parameter int unsigned MIN_COST = 4,
   parameter int unsigned MAX_COST = 31
) (
   input  logic         clk,
   input  logic         reset_l,
   input  logic         start,
   input  logic         abort,
   input  logic [4:0]   cost,
   input  logic [127:0] salt,
   input  logic [575:0] key,
   output logic         ek_start,
   output logic         ek_use_salt,
   output logic [127:0] ek_salt,
   output logic [575:0] ek_key,
   input  logic         ek_done,
   output logic         busy,
   output logic         done,
   output logic [31:0]  rounds_left
);

   localparam int unsigned CntW = MAX_COST + 1;

   typedef enum logic [2:0] {
      StIdle, StSetupGo, StSetupWait, StKeyGo, StKeyWait, StSaltGo, StSaltWait, StFin
   } state_e;

   state_e            state_q;
   logic [CntW-1:0]   cnt_q;
   logic [127:0]      salt_q;
   logic [575:0]      key_q;
   logic              ek_start_q;
   logic              use_salt_q;
   logic              sel_salt_q;
   logic              busy_q;
   logic              done_q;

   logic [5:0]        cost_ext;
   logic [4:0]        eff_cost;
   logic [CntW-1:0]   cnt_load;
   logic [575:0]      salt_rep;

   // Compare in 6 bits so the upper clamp stays meaningful for any MAX_COST.
   always_comb begin
      cost_ext = {1'b0, cost};
      eff_cost = cost;
      if (cost_ext < 6'(MIN_COST)) begin
         eff_cost = 5'(MIN_COST);
      end else if (cost_ext > 6'(MAX_COST)) begin
         eff_cost = 5'(MAX_COST);
      end
      cnt_load = CntW'(1) << eff_cost;
   end

   always_comb begin
      salt_rep = '0;
      for (int i = 0; i < 18; i++) begin
         salt_rep[32*i +: 32] = salt_q[32*(i%4) +: 32];
      end
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         salt_q     <= '0;
         key_q      <= '0;
         ek_start_q <= 1'b0;
         use_salt_q <= 1'b0;
         sel_salt_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         ek_start_q <= 1'b0;
         done_q     <= 1'b0;
         if (abort) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            use_salt_q <= 1'b0;
            sel_salt_q <= 1'b0;
            busy_q     <= 1'b0;
         end else begin
            case (state_q)
               StIdle: begin
                  if (start) begin
                     salt_q     <= salt;
                     key_q      <= key;
                     cnt_q      <= cnt_load;
                     state_q    <= StSetupGo;
                     ek_start_q <= 1'b1;
                     use_salt_q <= 1'b1;
                     sel_salt_q <= 1'b0;
                     busy_q     <= 1'b1;
                  end
               end
               StSetupGo: state_q <= StSetupWait;
               StSetupWait: begin
                  if (ek_done) begin
                     state_q    <= StKeyGo;
                     ek_start_q <= 1'b1;
                     use_salt_q <= 1'b0;
                     sel_salt_q <= 1'b0;
                  end
               end
               StKeyGo: state_q <= StKeyWait;
               StKeyWait: begin
                  if (ek_done) begin
                     state_q    <= StSaltGo;
                     ek_start_q <= 1'b1;
                     sel_salt_q <= 1'b1;
                  end
               end
               StSaltGo: state_q <= StSaltWait;
               StSaltWait: begin
                  if (ek_done) begin
                     cnt_q      <= cnt_q - CntW'(1);
                     sel_salt_q <= 1'b0;
                     if (cnt_q == CntW'(1)) begin
                        state_q <= StFin;
                        done_q  <= 1'b1;
                     end else begin
                        state_q    <= StKeyGo;
                        ek_start_q <= 1'b1;
                     end
                  end
               end
               StFin: begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign ek_start    = ek_start_q;
   assign ek_use_salt = use_salt_q;
   assign ek_salt     = salt_q;
   assign ek_key      = sel_salt_q ? salt_rep : key_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign rounds_left = 32'(cnt_q);

endmodule

// File: tb/tb_eks_setup_sequencer.sv
// Bench for eks_setup_sequencer: table of full runs against an expandKey responder,
// plus hand-written abort, reset and stray-done sequences.
module tb_eks_setup_sequencer;

   typedef logic [575:0] w_t;

   typedef struct {
      logic [4:0]   cost;
      int           dly;
      logic [127:0] salt;
      logic [31:0]  kseed;
      logic         mid_start;
      logic [31:0]  exp_load;
      int           exp_calls;
   } vec_t;

   localparam logic [127:0] SaltA = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

   logic         clk = 1'b0;
   logic         reset_l;
   logic         start, abort;
   logic [4:0]   cost;
   logic [127:0] salt;
   logic [575:0] key;
   logic         ek_start, ek_use_salt, busy, done;
   logic [127:0] ek_salt;
   logic [575:0] ek_key;
   logic         ek_done, resp_done, stray_done;
   logic [31:0]  rounds_left;

   int checks = 0;
   int errors = 0;
   int n_start, n_done, n_bad, cd, dly, idx;
   bit auto_en;
   logic [575:0] exp_key;
   logic [127:0] exp_salt;
   logic [31:0]  cap_w17, cap_w4;
   vec_t vecs[5];

   assign ek_done = resp_done | stray_done;

   eks_setup_sequencer dut (
      .clk         (clk),
      .reset_l     (reset_l),
      .start       (start),
      .abort       (abort),
      .cost        (cost),
      .salt        (salt),
      .key         (key),
      .ek_start    (ek_start),
      .ek_use_salt (ek_use_salt),
      .ek_salt     (ek_salt),
      .ek_key      (ek_key),
      .ek_done     (ek_done),
      .busy        (busy),
      .done        (done),
      .rounds_left (rounds_left)
   );

   always #5 clk = ~clk;

   function automatic logic [575:0] repl(input logic [127:0] s);
      logic [575:0] r;
      for (int i = 0; i < 18; i++) r[32*i +: 32] = s[32*(i%4) +: 32];
      return r;
   endfunction

   function automatic logic [575:0] mk_key(input logic [31:0] seed);
      logic [575:0] r;
      for (int i = 0; i < 18; i++) r[32*i +: 32] = seed ^ (32'h0101_0101 * 32'(i + 1));
      return r;
   endfunction

   task automatic chk(input string name, input w_t act, input w_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // expandKey stand-in: answers each ek_start after dly cycles and classifies every call.
   initial begin
      resp_done = 1'b0;
      cd = 0;
      n_start = 0;
      n_done = 0;
      n_bad = 0;
      forever begin
         @(posedge clk);
         #1;
         resp_done = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) resp_done = 1'b1;
         end
         if (ek_start === 1'b1) begin
            if (auto_en) cd = dly;
            idx = n_start;
            n_start++;
            if (ek_salt !== exp_salt) n_bad++;
            if (idx == 0) begin
               if (ek_use_salt !== 1'b1 || ek_key !== exp_key) n_bad++;
            end else if (idx % 2 == 1) begin
               if (ek_use_salt !== 1'b0 || ek_key !== exp_key) n_bad++;
            end else begin
               if (ek_use_salt !== 1'b0 || ek_key !== repl(exp_salt)) n_bad++;
               if (idx == 2) begin
                  cap_w17 = ek_key[17*32 +: 32];
                  cap_w4  = ek_key[4*32 +: 32];
               end
            end
         end
         if (done === 1'b1) n_done++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic run_vec(input vec_t v, input bit chk_words);
      bit seen;
      auto_en  = 1'b1;
      dly      = v.dly;
      exp_key  = mk_key(v.kseed);
      exp_salt = v.salt;
      n_start = 0; n_done = 0; n_bad = 0;
      key = exp_key; salt = v.salt; cost = v.cost; start = 1'b1;
      step();
      start = 1'b0;
      chk("go_ek_start", w_t'(ek_start), w_t'(1'b1));
      chk("go_use_salt", w_t'(ek_use_salt), w_t'(1'b1));
      chk("go_busy", w_t'(busy), w_t'(1'b1));
      chk("load_rounds", w_t'(rounds_left), w_t'(v.exp_load));
      if (v.mid_start) begin
         repeat (20) step();
         key = mk_key(~v.kseed); salt = ~v.salt; cost = 5'd0; start = 1'b1;
         step();
         start = 1'b0;
      end
      seen = 1'b0;
      for (int c = 0; c < 20000; c++) begin
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      chk("done_seen", w_t'(seen), w_t'(1'b1));
      chk("fin_busy", w_t'(busy), w_t'(1'b1));
      chk("fin_rounds", w_t'(rounds_left), w_t'(0));
      step();
      chk("post_busy", w_t'(busy), w_t'(1'b0));
      chk("post_done", w_t'(done), w_t'(1'b0));
      repeat (4) step();
      chk("call_count", w_t'(n_start), w_t'(v.exp_calls));
      chk("done_count", w_t'(n_done), w_t'(1));
      chk("call_shape", w_t'(n_bad), w_t'(0));
      chk("ek_salt_kept", w_t'(ek_salt), w_t'(v.salt));
      if (chk_words) begin
         chk("rep_word17", w_t'(cap_w17), w_t'(32'hFEDC_BA98));
         chk("rep_word4", w_t'(cap_w4), w_t'(32'h7654_3210));
      end
   endtask

   initial begin
      bit reached, any;
      reset_l = 1'b0; start = 1'b0; abort = 1'b0; cost = '0; salt = '0; key = '0;
      stray_done = 1'b0; auto_en = 1'b0; dly = 3;
      exp_key = '0; exp_salt = '0;
      vecs[0] = '{cost:5'd4, dly:3, salt:SaltA, kseed:32'hA5A5_0001, mid_start:1'b0,
                  exp_load:32'd16, exp_calls:33};
      vecs[1] = '{cost:5'd0, dly:1, salt:128'h1111_2222_3333_4444_5555_6666_7777_8888,
                  kseed:32'h0BAD_F00D, mid_start:1'b0, exp_load:32'd16, exp_calls:33};
      vecs[2] = '{cost:5'd5, dly:2, salt:128'hDEAD_BEEF_0000_1111_CAFE_BABE_2222_3333,
                  kseed:32'h1234_5678, mid_start:1'b0, exp_load:32'd32, exp_calls:65};
      vecs[3] = '{cost:5'd4, dly:3, salt:128'h0F0F_0F0F_F0F0_F0F0_AAAA_5555_3C3C_C3C3,
                  kseed:32'h7777_0000, mid_start:1'b1, exp_load:32'd16, exp_calls:33};
      vecs[4] = '{cost:5'd7, dly:1, salt:128'h8000_0000_0000_0001_4000_0000_0000_0002,
                  kseed:32'hFFFF_0000, mid_start:1'b0, exp_load:32'd128, exp_calls:257};

      repeat (2) step();
      chk("rst_ek_start", w_t'(ek_start), w_t'(1'b0));
      chk("rst_use_salt", w_t'(ek_use_salt), w_t'(1'b0));
      chk("rst_busy", w_t'(busy), w_t'(1'b0));
      chk("rst_done", w_t'(done), w_t'(1'b0));
      chk("rst_rounds", w_t'(rounds_left), w_t'(0));
      chk("rst_ek_salt", w_t'(ek_salt), w_t'(0));
      chk("rst_ek_key", w_t'(ek_key), w_t'(0));
      reset_l = 1'b1;
      step();
      stray_done = 1'b1;
      repeat (2) step();
      stray_done = 1'b0;
      chk("idle_stray_busy", w_t'(busy), w_t'(1'b0));
      chk("idle_stray_start", w_t'(ek_start), w_t'(1'b0));

      for (int i = 0; i < 5; i++) run_vec(vecs[i], i == 0);

      // Maximum cost: 2^31 load, first three rounds, then abort out.
      auto_en = 1'b1; dly = 2;
      exp_key = mk_key(32'h3131_3131); exp_salt = SaltA;
      n_start = 0; n_done = 0; n_bad = 0;
      key = exp_key; salt = SaltA; cost = 5'd31; start = 1'b1;
      step();
      start = 1'b0;
      chk("max_load", w_t'(rounds_left), w_t'(32'h8000_0000));
      reached = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (n_start >= 8) begin
            reached = 1'b1;
            break;
         end
         step();
      end
      chk("max_reach_round4", w_t'(reached), w_t'(1'b1));
      chk("max_rounds_after3", w_t'(rounds_left), w_t'(32'h7FFF_FFFD));
      chk("max_call_shape", w_t'(n_bad), w_t'(0));
      auto_en = 1'b0; abort = 1'b1;
      step();
      abort = 1'b0;
      chk("max_abort_busy", w_t'(busy), w_t'(1'b0));
      chk("max_abort_rounds", w_t'(rounds_left), w_t'(0));
      repeat (5) step();

      // Abort in KEY_WAIT with ek_done in the same cycle.
      n_start = 0; n_done = 0; n_bad = 0;
      exp_key = mk_key(32'h5555_AAAA); exp_salt = SaltA;
      key = exp_key; salt = SaltA; cost = 5'd4; start = 1'b1;
      step();
      start = 1'b0;
      step();
      stray_done = 1'b1;
      step();
      stray_done = 1'b0;
      chk("ab_key_go_start", w_t'(ek_start), w_t'(1'b1));
      chk("ab_key_go_use_salt", w_t'(ek_use_salt), w_t'(1'b0));
      step();
      stray_done = 1'b1; abort = 1'b1;
      step();
      stray_done = 1'b0; abort = 1'b0;
      chk("ab_busy", w_t'(busy), w_t'(1'b0));
      chk("ab_ek_start", w_t'(ek_start), w_t'(1'b0));
      chk("ab_done", w_t'(done), w_t'(1'b0));
      chk("ab_rounds", w_t'(rounds_left), w_t'(0));
      any = 1'b0;
      repeat (10) begin
         step();
         if (ek_start !== 1'b0 || done !== 1'b0 || busy !== 1'b0) any = 1'b1;
      end
      chk("ab_quiet", w_t'(any), w_t'(1'b0));
      chk("ab_done_count", w_t'(n_done), w_t'(0));

      // Stray ek_done in SETUP_GO, then async reset in SALT_WAIT.
      n_start = 0; n_done = 0; n_bad = 0;
      exp_key = mk_key(32'h6666_9999); exp_salt = SaltA;
      key = exp_key; salt = SaltA; cost = 5'd4; start = 1'b1;
      step();
      start = 1'b0;
      stray_done = 1'b1;
      step();
      stray_done = 1'b0;
      chk("stray_no_advance", w_t'(ek_start), w_t'(1'b0));
      chk("stray_use_salt", w_t'(ek_use_salt), w_t'(1'b1));
      step();
      chk("stray_not_kept", w_t'(ek_start), w_t'(1'b0));
      stray_done = 1'b1;
      step();
      stray_done = 1'b0;
      chk("rs_key_go", w_t'(ek_start), w_t'(1'b1));
      step();
      stray_done = 1'b1;
      step();
      stray_done = 1'b0;
      chk("rs_salt_go", w_t'(ek_start), w_t'(1'b1));
      chk("rs_salt_key", w_t'(ek_key), w_t'(repl(SaltA)));
      step();
      chk("rs_busy_before", w_t'(busy), w_t'(1'b1));
      #2;
      reset_l = 1'b0;
      #1;
      chk("rs_ek_start", w_t'(ek_start), w_t'(1'b0));
      chk("rs_use_salt", w_t'(ek_use_salt), w_t'(1'b0));
      chk("rs_busy", w_t'(busy), w_t'(1'b0));
      chk("rs_done", w_t'(done), w_t'(1'b0));
      chk("rs_rounds", w_t'(rounds_left), w_t'(0));
      chk("rs_ek_salt", w_t'(ek_salt), w_t'(0));
      chk("rs_ek_key", w_t'(ek_key), w_t'(0));
      step();
      reset_l = 1'b1;
      repeat (3) step();
      chk("rs_idle_busy", w_t'(busy), w_t'(1'b0));
      chk("rs_idle_start", w_t'(ek_start), w_t'(1'b0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
